bcd_message_streamer: RTL
=========================

# bcd_message_streamer

Multi-channel successor to the combinational sign/BCD/terminator message composer. It takes a snapshot of one channel's signed BCD value on request and streams the ASCII message byte by byte over a valid/ready byte interface to the UART transmitter. Requesting channels are served round-robin. It adds a configurable digit count and digit order, and it flags invalid BCD digits.

## Interface
- DIGITS, 4: BCD digits per channel (1..8).
- CHANNELS, 2: number of request channels (1..8). CH_W = max(1, clog2(CHANNELS)).
- MSD_FIRST, 0: 0 sends the least-significant digit first (legacy order); 1 sends the most-significant digit first.
- POS_CHAR, 8'd33: sign byte ('!') when signo=1.
- NEG_CHAR, 8'd35: sign byte ('#') when signo=0.
- ERR_CHAR, 8'd63: byte ('?') sent in place of a digit greater than 9.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bcd  in  CHANNELS*DIGITS*4  channel i occupies bits [i*DIGITS*4 +: DIGITS*4]; digit 0 is in the low nibble.
- signo  in  CHANNELS  sign per channel; 1 = positive.
- term_char  in  8  terminator byte, shared by all channels.
- req  in  CHANNELS  per-channel request; a high level sets the channel's pending bit.
- ack  out  CHANNELS  one-cycle pulse in the cycle channel i is captured.
- tx_data  out  8  byte being offered.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- busy  out  1  high whenever the FSM is not in IDLE.
- msg_done  out  1  one-cycle pulse after the terminator is accepted.
- msg_chan  out  CH_W  channel of the current or last message.
- digit_err  out  1  valid in the msg_done cycle; 1 if any digit of that message was greater than 9.

## Operation
- Each channel has a pending bit.
  - Set by req[i]=1.
  - Cleared when the channel is captured. Capture wins over a simultaneous req, so a held req re-arms one cycle later.
- FSM states: IDLE, SIGN, DIGIT, TERM.
- IDLE with any pending bit set:
  - Round-robin pick, searching from last_served+1 with wrap-around. last_served resets to CHANNELS-1, so channel 0 wins first.
  - Snapshot that channel's bcd, signo and term_char.
  - Pulse ack[i], set msg_chan, clear the error accumulator, go to SIGN.
- SIGN: offer POS_CHAR or NEG_CHAR. On accept, go to DIGIT with index k=0.
- DIGIT: offer ASCII digit d+8'd48, or ERR_CHAR with err accumulator set if d>9.
  - d is snapshot digit k when MSD_FIRST=0, and digit DIGITS-1-k when MSD_FIRST=1.
  - On accept: if k=DIGITS-1 go to TERM, else k+1.
- TERM: offer the snapshot terminator. On accept go to IDLE, and pulse msg_done with digit_err in the following cycle.
- Input changes after capture do not affect the message in flight.

## Timing
- Reset (asynchronous, immediate):
  - tx_valid=0, tx_data=0, ack=0, busy=0, msg_done=0, msg_chan=0, digit_err=0.
  - Pending bits cleared, FSM in IDLE, last_served=CHANNELS-1.
- Reset mid-message aborts the message. No partial resume after release.
- Capture happens in cycle C. The sign byte is valid in C+1.
- tx_data and tx_valid are registered. While tx_valid && !tx_ready, tx_data holds stable. tx_valid never drops without acceptance, except on reset.
- Message length is DIGITS+2 bytes. With tx_ready held high, one message takes DIGITS+3 cycles, capture cycle included.
- Back-to-back operation:
  - Terminator accepted at T.
  - T+1: msg_done=1 and, if a channel is pending, capture and ack in the same cycle.
  - T+2: next sign byte valid.
- A req arriving while busy is held pending. It is never lost.

## Test plan
- CHANNELS=1, DIGITS=4, MSD_FIRST=0, bcd=16'h1234, signo=1, term_char=8'h0A, tx_ready=1, one req pulse -> bytes 21 34 33 32 31 0A on consecutive cycles starting one cycle after the ack. msg_done=1 one cycle after 0A is accepted; digit_err=0.
- MSD_FIRST=1, bcd=16'h1234, signo=0 -> bytes 23 31 32 33 34 0A.
- tx_ready alternating 0/1, and bcd changed to 16'h9999 after capture -> exactly 6 bytes of the original value. tx_data is stable during every stall, with no duplicated or skipped bytes.
- CHANNELS=2, req=2'b11 held high -> captures alternate 0,1,0,1. ack and msg_chan match each capture. There is a 1-cycle gap between each terminator and the next sign byte.
- bcd=16'h12A4, signo=1 -> bytes 21 34 3F 32 31 0A with digit_err=1 at msg_done. A following message with bcd=16'h0000 gives digit_err=0.
- reset_n low while the second digit is stalled -> tx_valid, busy and ack go to 0 immediately and pending bits clear. After release there is no output until a new req.

Source files
------------

// File: rtl/bcd_message_streamer.sv
// Round-robin multi-channel signed-BCD to ASCII message streamer.
// Snapshots one channel per message and emits sign, digits and terminator over a valid/ready byte port.
module bcd_message_streamer #(
  parameter int         DIGITS    = 4,
  parameter int         CHANNELS  = 2,
  parameter bit         MSD_FIRST = 1'b0,
  parameter logic [7:0] POS_CHAR  = 8'd33,
  parameter logic [7:0] NEG_CHAR  = 8'd35,
  parameter logic [7:0] ERR_CHAR  = 8'd63,
  localparam int        CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [CHANNELS*DIGITS*4-1:0] bcd,
  input  logic [CHANNELS-1:0]          signo,
  input  logic [7:0]                   term_char,
  input  logic [CHANNELS-1:0]          req,
  output logic [CHANNELS-1:0]          ack,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         msg_done,
  output logic [CH_W-1:0]              msg_chan,
  output logic                         digit_err
);

  localparam int             K_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int             MSG_W  = DIGITS * 4;
  localparam logic [K_W-1:0] K_LAST = K_W'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, TERM} state_t;

  state_t              state_reg, state_next;
  logic [CHANNELS-1:0] pending_reg, pending_next;
  logic [CH_W-1:0]     last_reg, last_next;
  logic [CH_W-1:0]     pick;
  logic                any_pending;
  int                  rr_c;
  logic [MSG_W-1:0]    snap_bcd_reg, snap_bcd_next;
  logic                snap_sign_reg, snap_sign_next;
  logic [7:0]          snap_term_reg, snap_term_next;
  logic [K_W-1:0]      k_reg, k_next;
  logic                err_reg, err_next;
  logic [7:0]          tx_data_reg, tx_data_next;
  logic                tx_valid_reg, tx_valid_next;
  logic                msg_done_reg, msg_done_next;
  logic                digit_err_reg, digit_err_next;
  logic [CH_W-1:0]     msg_chan_reg, msg_chan_next;
  logic [3:0]          digit;

  function automatic logic [3:0] digit_at(input logic [MSG_W-1:0] v, input logic [K_W-1:0] k);
    int idx;
    idx = MSD_FIRST ? (DIGITS - 1 - int'(k)) : int'(k);
    return v[idx*4 +: 4];
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? ERR_CHAR : (8'd48 + {4'd0, d});
  endfunction

  // Search downward so the channel closest after last_reg is the one left in pick.
  always_comb begin
    any_pending = 1'b0;
    pick        = '0;
    rr_c        = 0;
    for (int off = CHANNELS; off >= 1; off--) begin
      rr_c = (int'(last_reg) + off) % CHANNELS;
      if (pending_reg[rr_c]) begin
        any_pending = 1'b1;
        pick        = CH_W'(rr_c);
      end
    end
  end

  assign ack = (state_reg == IDLE && any_pending) ? (CHANNELS'(1) << pick) : '0;

  // Capture clears a channel's pending bit even if req is still high this cycle.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pending
    assign pending_next[gi] = (pending_reg[gi] | req[gi]) & ~ack[gi];
  end

  always_comb begin
    state_next     = state_reg;
    last_next      = last_reg;
    snap_bcd_next  = snap_bcd_reg;
    snap_sign_next = snap_sign_reg;
    snap_term_next = snap_term_reg;
    k_next         = k_reg;
    err_next       = err_reg;
    tx_data_next   = tx_data_reg;
    tx_valid_next  = tx_valid_reg;
    msg_done_next  = 1'b0;
    digit_err_next = digit_err_reg;
    msg_chan_next  = msg_chan_reg;
    digit          = 4'd0;
    case (state_reg)
      IDLE: begin
        if (any_pending) begin
          state_next     = SIGN;
          last_next      = pick;
          msg_chan_next  = pick;
          snap_bcd_next  = bcd[int'(pick)*MSG_W +: MSG_W];
          snap_sign_next = signo[pick];
          snap_term_next = term_char;
          err_next       = 1'b0;
          tx_valid_next  = 1'b1;
          tx_data_next   = signo[pick] ? POS_CHAR : NEG_CHAR;
        end
      end
      SIGN: begin
        if (tx_ready) begin
          state_next   = DIGIT;
          k_next       = '0;
          digit        = digit_at(snap_bcd_reg, '0);
          tx_data_next = digit_char(digit);
          err_next     = err_reg | (digit > 4'd9);
        end
      end
      DIGIT: begin
        if (tx_ready) begin
          if (k_reg == K_LAST) begin
            state_next   = TERM;
            tx_data_next = snap_term_reg;
          end else begin
            k_next       = K_W'(k_reg + 1'b1);
            digit        = digit_at(snap_bcd_reg, K_W'(k_reg + 1'b1));
            tx_data_next = digit_char(digit);
            err_next     = err_reg | (digit > 4'd9);
          end
        end
      end
      TERM: begin
        if (tx_ready) begin
          state_next     = IDLE;
          tx_valid_next  = 1'b0;
          msg_done_next  = 1'b1;
          digit_err_next = err_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pending_reg   <= '0;
      last_reg      <= CH_W'(CHANNELS - 1);
      snap_bcd_reg  <= '0;
      snap_sign_reg <= 1'b0;
      snap_term_reg <= 8'd0;
      k_reg         <= '0;
      err_reg       <= 1'b0;
      tx_data_reg   <= 8'd0;
      tx_valid_reg  <= 1'b0;
      msg_done_reg  <= 1'b0;
      digit_err_reg <= 1'b0;
      msg_chan_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      pending_reg   <= pending_next;
      last_reg      <= last_next;
      snap_bcd_reg  <= snap_bcd_next;
      snap_sign_reg <= snap_sign_next;
      snap_term_reg <= snap_term_next;
      k_reg         <= k_next;
      err_reg       <= err_next;
      tx_data_reg   <= tx_data_next;
      tx_valid_reg  <= tx_valid_next;
      msg_done_reg  <= msg_done_next;
      digit_err_reg <= digit_err_next;
      msg_chan_reg  <= msg_chan_next;
    end
  end

  assign tx_data   = tx_data_reg;
  assign tx_valid  = tx_valid_reg;
  assign busy      = (state_reg != IDLE);
  assign msg_done  = msg_done_reg;
  assign msg_chan  = msg_chan_reg;
  assign digit_err = digit_err_reg;

endmodule
